// File: rtl/imem_uart_loader.sv
// imem_uart_loader: boot loader that fills instruction memory from a UART byte
// stream while holding the core in reset.
//   Stream format: 4-byte little-endian word count N, then N little-endian words.
//   Words are written at byte addresses 0, 4, 8, ...; a one-byte ACK/NAK is sent
//   through the UART transmitter when loading finishes or the header is rejected.
// Ports:
//   clk, rstn             - clock, asynchronous active-low reset
//   rx_data, rx_valid     - byte stream from uart_rx (one-cycle strobe per byte)
//   imem_we/addr/wdata    - instruction memory write port (one pulse per word)
//   tx_data, tx_valid     - byte to uart_tx, held until tx_ready
//   tx_ready              - uart_tx accepts on an edge with tx_valid & tx_ready
//   core_rstn             - core reset (active-low), released after ACK accepted
//   done                  - load complete and core released
//   err                   - length header rejected
module imem_uart_loader #(
  parameter int unsigned ADDR_W   = 12,
  parameter logic [7:0]  ACK_BYTE = 8'hAA,
  parameter logic [7:0]  NAK_BYTE = 8'hEE
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              core_rstn,
  output logic              done,
  output logic              err
);

  localparam int unsigned CW    = ADDR_W - 2;
  localparam int unsigned WORDS = (2 ** ADDR_W) / 4;
  localparam logic [CW:0] ONE   = 1;

  typedef enum logic [2:0] {LEN, DATA, ACK, RUN, ERR} state_t;

  state_t         state, state_d;
  logic [1:0]     byte_cnt, byte_cnt_d;
  logic [CW-1:0]  word_cnt, word_cnt_d;
  // word count needs one extra bit: N may equal the full capacity
  logic [CW:0]    len, len_d;
  logic [23:0]    asm_buf, asm_buf_d;
  logic [31:0]    word;

  logic              imem_we_d;
  logic [ADDR_W-1:0] imem_addr_d;
  logic [31:0]       imem_wdata_d;
  logic [7:0]        tx_data_d;
  logic              tx_valid_d, core_rstn_d, done_d, err_d;

  // the 4th byte completes the word directly from rx_data
  assign word = {rx_data, asm_buf};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= LEN;
      byte_cnt   <= '0;
      word_cnt   <= '0;
      len        <= '0;
      asm_buf    <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      tx_data    <= '0;
      tx_valid   <= 1'b0;
      core_rstn  <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_d;
      byte_cnt   <= byte_cnt_d;
      word_cnt   <= word_cnt_d;
      len        <= len_d;
      asm_buf    <= asm_buf_d;
      imem_we    <= imem_we_d;
      imem_addr  <= imem_addr_d;
      imem_wdata <= imem_wdata_d;
      tx_data    <= tx_data_d;
      tx_valid   <= tx_valid_d;
      core_rstn  <= core_rstn_d;
      done       <= done_d;
      err        <= err_d;
    end
  end

  always_comb begin
    state_d      = state;
    byte_cnt_d   = byte_cnt;
    word_cnt_d   = word_cnt;
    len_d        = len;
    asm_buf_d    = asm_buf;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr;
    imem_wdata_d = imem_wdata;
    tx_data_d    = tx_data;
    tx_valid_d   = tx_valid;
    core_rstn_d  = core_rstn;
    done_d       = done;
    err_d        = err;

    // byte assembly is shared by the header and data phases
    if (rx_valid && (state == LEN || state == DATA)) begin
      byte_cnt_d = byte_cnt + 2'd1;
      case (byte_cnt)
        2'd0:    asm_buf_d[7:0]   = rx_data;
        2'd1:    asm_buf_d[15:8]  = rx_data;
        2'd2:    asm_buf_d[23:16] = rx_data;
        default: ;
      endcase
    end

    case (state)
      LEN: begin
        if (rx_valid && byte_cnt == 2'd3) begin
          if (word == 32'd0) begin
            state_d    = ACK;
            tx_valid_d = 1'b1;
            tx_data_d  = ACK_BYTE;
          end else if (word <= 32'(WORDS)) begin
            state_d    = DATA;
            len_d      = word[CW:0];
            word_cnt_d = '0;
          end else begin
            state_d    = ERR;
            tx_valid_d = 1'b1;
            tx_data_d  = NAK_BYTE;
            err_d      = 1'b1;
          end
        end
      end
      DATA: begin
        if (rx_valid && byte_cnt == 2'd3) begin
          imem_we_d    = 1'b1;
          imem_wdata_d = word;
          imem_addr_d  = {word_cnt, 2'b00};
          word_cnt_d   = word_cnt + 1'b1;
          if (({1'b0, word_cnt} + ONE) == len) begin
            state_d    = ACK;
            tx_valid_d = 1'b1;
            tx_data_d  = ACK_BYTE;
          end
        end
      end
      ACK: begin
        if (tx_ready) begin
          state_d     = RUN;
          tx_valid_d  = 1'b0;
          core_rstn_d = 1'b1;
          done_d      = 1'b1;
        end
      end
      ERR: begin
        if (tx_valid && tx_ready) tx_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_imem_uart_loader.sv
module tb_imem_uart_loader;

  localparam int unsigned ADDR_W = 12;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic [7:0]        rx_data = '0;
  logic              rx_valid = 1'b0;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready = 1'b1;
  logic              core_rstn;
  logic              done;
  logic              err;

  int unsigned n_asserts = 0;
  int unsigned n_fail    = 0;
  int unsigned we_count  = 0;
  logic        prev_we   = 1'b0;
  logic [43:0] sb[$];

  imem_uart_loader #(.ADDR_W(ADDR_W), .ACK_BYTE(8'hAA), .NAK_BYTE(8'hEE)) dut (
    .clk(clk), .rstn(rstn), .rx_data(rx_data), .rx_valid(rx_valid),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .core_rstn(core_rstn), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // scoreboard consumer: every write pulse must match the oldest expected write
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      logic [43:0] e;
      we_count++;
      chk("we_single_cycle", 32'(prev_we), 32'd0);
      if (sb.size() == 0) begin
        chk("we_unexpected", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("we_addr", 32'(imem_addr), 32'(e[43:32]));
        chk("we_data", imem_wdata, e[31:0]);
      end
    end
    prev_we = imem_we;
  end

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic send4(input logic [31:0] w, input bit gap);
    for (int k = 0; k < 4; k++) begin
      send_byte(w[8*k +: 8]);
      if (gap && k < 3) begin
        rx_valid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic send_word(input logic [11:0] addr, input logic [31:0] w, input bit gap);
    sb.push_back({addr, w});
    send4(w, gap);
    chk("we_latency", 32'(imem_we), 32'd1);
    chk("we_latency_addr", 32'(imem_addr), 32'(addr));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_we"}, 32'(imem_we), 32'd0);
    chk({tag, "_addr"}, 32'(imem_addr), 32'd0);
    chk({tag, "_wdata"}, imem_wdata, 32'd0);
    chk({tag, "_txv"}, 32'(tx_valid), 32'd0);
    chk({tag, "_txd"}, 32'(tx_data), 32'd0);
    chk({tag, "_crst"}, 32'(core_rstn), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
  endtask

  task automatic do_reset();
    rx_valid = 1'b0;
    rstn = 1'b0;
    #1;
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // after the final 4th byte: ACK presented now, accepted on the next edge
  task automatic expect_ack_accept(input string tag);
    chk({tag, "_ack_txv"}, 32'(tx_valid), 32'd1);
    chk({tag, "_ack_txd"}, 32'(tx_data), 32'hAA);
    chk({tag, "_ack_crst_low"}, 32'(core_rstn), 32'd0);
    @(posedge clk);
    #1;
    chk({tag, "_acc_txv"}, 32'(tx_valid), 32'd0);
    chk({tag, "_acc_crst"}, 32'(core_rstn), 32'd1);
    chk({tag, "_acc_done"}, 32'(done), 32'd1);
    chk({tag, "_acc_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    int unsigned base;
    #1;
    check_reset_outputs("init");

    // 1: two words with idle gaps between bytes
    do_reset();
    tx_ready = 1'b1;
    base = we_count;
    send4(32'd2, 1'b1);
    send_word(12'h000, 32'h00000013, 1'b1);
    send_word(12'h004, 32'h00100093, 1'b1);
    rx_valid = 1'b0;
    expect_ack_accept("t1");
    send4(32'hDEADBEEF, 1'b0);
    rx_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("t1_we_count", we_count - base, 32'd2);
    chk("t1_run_done", 32'(done), 32'd1);
    chk("t1_run_txv", 32'(tx_valid), 32'd0);

    // 2: three words, bytes every cycle
    do_reset();
    base = we_count;
    send4(32'd3, 1'b0);
    send_word(12'h000, 32'h11223344, 1'b0);
    send_word(12'h004, 32'hA5A55A5A, 1'b0);
    send_word(12'h008, 32'hCAFEF00D, 1'b0);
    rx_valid = 1'b0;
    expect_ack_accept("t2");
    chk("t2_we_count", we_count - base, 32'd3);

    // 3: header one above capacity is rejected
    do_reset();
    base = we_count;
    send4(32'd1025, 1'b0);
    rx_valid = 1'b0;
    chk("t3_err", 32'(err), 32'd1);
    chk("t3_txv", 32'(tx_valid), 32'd1);
    chk("t3_txd", 32'(tx_data), 32'hEE);
    chk("t3_crst", 32'(core_rstn), 32'd0);
    send4(32'h00000001, 1'b0);
    send4(32'h12345678, 1'b0);
    rx_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("t3_we_count", we_count - base, 32'd0);
    chk("t3_err_hold", 32'(err), 32'd1);
    chk("t3_txv_drop", 32'(tx_valid), 32'd0);
    chk("t3_crst_hold", 32'(core_rstn), 32'd0);
    chk("t3_done", 32'(done), 32'd0);

    // 4: zero-length load acknowledges immediately
    do_reset();
    base = we_count;
    send4(32'd0, 1'b0);
    rx_valid = 1'b0;
    expect_ack_accept("t4");
    chk("t4_we_count", we_count - base, 32'd0);

    // 5: transmitter stalls for 10 cycles
    do_reset();
    tx_ready = 1'b0;
    send4(32'd1, 1'b0);
    send_word(12'h000, 32'h0badc0de, 1'b0);
    rx_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("t5_stall_txv", 32'(tx_valid), 32'd1);
      chk("t5_stall_txd", 32'(tx_data), 32'hAA);
      chk("t5_stall_crst", 32'(core_rstn), 32'd0);
      @(posedge clk);
      #1;
    end
    tx_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("t5_acc_txv", 32'(tx_valid), 32'd0);
    chk("t5_acc_done", 32'(done), 32'd1);
    chk("t5_acc_crst", 32'(core_rstn), 32'd1);

    // 6: reset mid-word, then a fresh load
    do_reset();
    send4(32'd2, 1'b0);
    send_word(12'h000, 32'h01010101, 1'b0);
    send_byte(8'h77);
    send_byte(8'h66);
    rx_valid = 1'b0;
    #1;
    rstn = 1'b0;
    #1;
    check_reset_outputs("t6_async");
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    send4(32'd1, 1'b0);
    send_word(12'h000, 32'h76543210, 1'b0);
    rx_valid = 1'b0;
    expect_ack_accept("t6");

    // 7: full capacity, last address 0xFFC
    do_reset();
    base = we_count;
    send4(32'd1024, 1'b0);
    chk("t7_no_err", 32'(err), 32'd0);
    for (int i = 0; i < 1024; i++) begin
      send_word(12'(4 * i), $urandom, 1'b0);
    end
    rx_valid = 1'b0;
    expect_ack_accept("t7");
    chk("t7_we_count", we_count - base, 32'd1024);

    @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
